load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, response error codes,
// FSM state constants and the request legality/alignment decoder.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE   = 2'b00;
    localparam lsu_state_t ST_ACCESS = 2'b01;
    localparam lsu_state_t ST_RESP   = 2'b10;

    // Illegal funct3 wins over misalignment; alignment is only judged for legal sizes.
    function automatic logic [1:0] lsu_decode(input logic store, input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
        logic       legal;
        logic [1:0] err;
        if (store) begin
            legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        end else begin
            legal = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
        end
        if (!legal) begin
            err = ERR_ILLEGAL;
        end else if ((funct3[1:0] == 2'b01) && addr_lo[0]) begin
            err = ERR_MISALIGN;
        end else if ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)) begin
            err = ERR_MISALIGN;
        end else begin
            err = ERR_OK;
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store data replication and
// load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  lane_b_s;
    logic [15:0] lane_h_s;

    // Size-dependent lane steering; funct3[2] selects zero extension.
    always_comb begin
        be_o     = 4'b0000;
        wdata_o  = 32'h0000_0000;
        ldata_o  = 32'h0000_0000;
        lane_b_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
        lane_h_s = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                ldata_o = funct3_i[2] ? {24'h00_0000, lane_b_s}
                                      : {{24{lane_b_s[7]}}, lane_b_s};
            end
            2'b01: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                ldata_o = funct3_i[2] ? {16'h0000, lane_h_s}
                                      : {{16{lane_h_s[15]}}, lane_h_s};
            end
            2'b10: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                ldata_o = rdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
                ldata_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes a core request, runs one word
// access with a bounded wait for mem_ack, and returns a one-cycle response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t        state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [1:0]        resp_err_q, resp_err_d;

    logic [1:0]  dec_err_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ld_data_s;
    logic        access_s;

    assign dec_err_s = lsu_decode(req_store, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .be_o      (be_s),
        .wdata_o   (wdata_s),
        .ldata_o   (ld_data_s)
    );

    // Next-state logic; response fields are loaded only on the transition into RESP.
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_rdata_d = 32'h0000_0000;
        resp_err_d   = ERR_OK;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr[ADDR_W+1:0];
                    wdata_d  = req_wdata;
                    cnt_d    = {CNT_W{1'b0}};
                    if (dec_err_s == ERR_OK) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d    = ST_RESP;
                        resp_err_d = dec_err_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    resp_rdata_d = store_q ? 32'h0000_0000 : ld_data_s;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = ST_RESP;
                    resp_err_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= {(ADDR_W+2){1'b0}};
            wdata_q      <= 32'h0000_0000;
            cnt_q        <= {CNT_W{1'b0}};
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= ERR_OK;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign access_s   = (state_q == ST_ACCESS);
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = access_s;
    assign mem_we     = access_s & store_q;
    assign mem_addr   = access_s ? addr_q[ADDR_W+1:2] : {ADDR_W{1'b0}};
    assign mem_be     = access_s ? be_s : 4'b0000;
    assign mem_wdata  = access_s ? wdata_s : 32'h0000_0000;

endmodule
